// File: rtl/fb_pkg.sv
// Shared geometry, address layout and scan-state encoding for the framebuffer
// scanout path.
package fb_pkg;

  localparam int FB_WIDTH          = 480;
  localparam int FB_HEIGHT         = 272;
  localparam int FB_WORDS_PER_LINE = 120;
  localparam int FB_WORDS          = 32640;
  localparam int FB_BUF_BIT        = 15;
  localparam int FB_ADDR_W         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  // Pixel x=4k+i lives in byte lane i of word k.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding fetched framebuffer words.
module fb_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_C);
  assign count    = count_q;
  // Head word is visible combinationally so the unpacker can swap words without a bubble.
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fb_scanout_reader.sv
// Fetches one framebuffer over an Avalon-MM pipelined read master and streams
// its pixels in raster order on Avalon-ST, one frame per enable cycle.
module fb_scanout_reader
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_PENDING = 4,
  parameter int FRAME_W     = FB_WIDTH,
  parameter int FRAME_H     = FB_HEIGHT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        avm_fbuff_read,
  output logic [15:0] avm_fbuff_address,
  input  logic        avm_fbuff_waitrequest,
  input  logic [31:0] avm_fbuff_readdata,
  input  logic        avm_fbuff_readdatavalid,
  input  logic        avs_ctrl_write,
  input  logic [1:0]  avs_ctrl_writedata,
  output logic [3:0]  avs_ctrl_readdata,
  output logic [7:0]  aso_pix_data,
  output logic        aso_pix_valid,
  input  logic        aso_pix_ready,
  output logic        aso_pix_sop,
  output logic        aso_pix_eop,
  output logic        frame_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_PENDING + 1);
  localparam int XW = $clog2(FRAME_W);
  localparam int YW = $clog2(FRAME_H);

  localparam logic [CW:0]   DEPTH_C   = (CW+1)'(FIFO_DEPTH);
  localparam logic [OW-1:0] MAX_C     = OW'(MAX_PENDING);
  localparam logic [14:0]   LAST_WORD = 15'(FRAME_W * FRAME_H / 4 - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(FRAME_H - 1);

  scan_state_t   state_q, state_d;
  logic          enable_q, enable_d;
  logic          pending_buf_q, pending_buf_d;
  logic          active_buf_q, active_buf_d;
  logic [14:0]   word_index_q, word_index_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [31:0]   word_q, word_d;
  logic          held_q, held_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          frame_done_q, frame_done_d;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_data;
  logic [CW-1:0] fifo_count;

  logic [CW:0]   credit_sum;
  logic          issue_ok;
  logic          accept;
  logic          resp;
  logic          pix_fire;
  logic          last_byte;

  fb_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (resp),
    .push_data (avm_fbuff_readdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Every request in flight owns a FIFO slot, so a returning word always fits.
  always_comb begin
    credit_sum = {{(CW+1-OW){1'b0}}, outstanding_q} + {1'b0, fifo_count};
    issue_ok   = (state_q == FETCH) && (outstanding_q < MAX_C) &&
                 (credit_sum < DEPTH_C) && !fifo_full;
    accept     = issue_ok && !avm_fbuff_waitrequest;
    resp       = avm_fbuff_readdatavalid && (outstanding_q != '0);
    pix_fire   = held_q && aso_pix_ready;
    last_byte  = (byte_idx_q == 2'd3);
    fifo_pop   = !fifo_empty && (!held_q || (pix_fire && last_byte));
  end

  assign avm_fbuff_read    = issue_ok;
  assign avm_fbuff_address = {active_buf_q, word_index_q};
  assign avs_ctrl_readdata = {(state_q != IDLE), active_buf_q, pending_buf_q, enable_q};
  assign aso_pix_valid     = held_q;
  assign aso_pix_data      = word_byte(word_q, byte_idx_q);
  assign aso_pix_sop       = held_q && (x_q == '0) && (y_q == '0);
  assign aso_pix_eop       = held_q && (x_q == X_LAST) && (y_q == Y_LAST);
  assign frame_done        = frame_done_q;

  always_comb begin
    state_d       = state_q;
    enable_d      = enable_q;
    pending_buf_d = pending_buf_q;
    active_buf_d  = active_buf_q;
    word_index_d  = word_index_q;
    outstanding_d = outstanding_q;
    word_d        = word_q;
    held_d        = held_q;
    byte_idx_d    = byte_idx_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_done_d  = pix_fire && aso_pix_eop;

    if (avs_ctrl_write) begin
      enable_d      = avs_ctrl_writedata[0];
      pending_buf_d = avs_ctrl_writedata[1];
    end

    case ({accept, resp})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    if (fifo_pop) begin
      word_d     = fifo_data;
      held_d     = 1'b1;
      byte_idx_d = 2'd0;
    end else if (pix_fire && last_byte) begin
      held_d     = 1'b0;
      byte_idx_d = 2'd0;
    end else if (pix_fire) begin
      byte_idx_d = byte_idx_q + 1'b1;
    end

    if (pix_fire) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // Buffer choice is sampled only here, so mid-frame writes wait for the next frame.
        if (enable_q) begin
          state_d      = FETCH;
          active_buf_d = pending_buf_q;
          word_index_d = '0;
          x_d          = '0;
          y_d          = '0;
        end
      end
      FETCH: begin
        if (accept) begin
          word_index_d = word_index_q + 15'd1;
          if (word_index_q == LAST_WORD) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (frame_done_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      enable_q      <= 1'b0;
      pending_buf_q <= 1'b0;
      active_buf_q  <= 1'b0;
      word_index_q  <= '0;
      outstanding_q <= '0;
      word_q        <= '0;
      held_q        <= 1'b0;
      byte_idx_q    <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      pending_buf_q <= pending_buf_d;
      active_buf_q  <= active_buf_d;
      word_index_q  <= word_index_d;
      outstanding_q <= outstanding_d;
      word_q        <= word_d;
      held_q        <= held_d;
      byte_idx_q    <= byte_idx_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader on a reduced 16x4 frame (16 words) so
// several complete frames fit in a short run.
module tb_fb_scanout_reader;

  localparam int W     = 16;
  localparam int H     = 4;
  localparam int PIX   = W * H;
  localparam int WORDS = PIX / 4;
  localparam int MAXP  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        avm_fbuff_read;
  logic [15:0] avm_fbuff_address;
  logic        avm_fbuff_waitrequest;
  logic [31:0] avm_fbuff_readdata;
  logic        avm_fbuff_readdatavalid;
  logic        avs_ctrl_write;
  logic [1:0]  avs_ctrl_writedata;
  logic [3:0]  avs_ctrl_readdata;
  logic [7:0]  aso_pix_data;
  logic        aso_pix_valid;
  logic        aso_pix_ready;
  logic        aso_pix_sop;
  logic        aso_pix_eop;
  logic        frame_done;

  always #5 clk = ~clk;

  fb_scanout_reader #(
    .FIFO_DEPTH  (8),
    .MAX_PENDING (MAXP),
    .FRAME_W     (W),
    .FRAME_H     (H)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .avm_fbuff_read          (avm_fbuff_read),
    .avm_fbuff_address       (avm_fbuff_address),
    .avm_fbuff_waitrequest   (avm_fbuff_waitrequest),
    .avm_fbuff_readdata      (avm_fbuff_readdata),
    .avm_fbuff_readdatavalid (avm_fbuff_readdatavalid),
    .avs_ctrl_write          (avs_ctrl_write),
    .avs_ctrl_writedata      (avs_ctrl_writedata),
    .avs_ctrl_readdata       (avs_ctrl_readdata),
    .aso_pix_data            (aso_pix_data),
    .aso_pix_valid           (aso_pix_valid),
    .aso_pix_ready           (aso_pix_ready),
    .aso_pix_sop             (aso_pix_sop),
    .aso_pix_eop             (aso_pix_eop),
    .frame_done              (frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Buffer 0 pixel p reads back as p; buffer 1 as 0x80|p, except the first
  // word of buffer 1 which is 0x44332211.
  function automatic logic [7:0] pix(input logic b, input int p);
    logic [7:0] v;
    if (b && p < 4) begin
      case (p)
        0:       v = 8'h11;
        1:       v = 8'h22;
        2:       v = 8'h33;
        default: v = 8'h44;
      endcase
    end else begin
      v = {b, 7'(p)};
    end
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    int w;
    w = int'(a[14:0]);
    return {pix(a[15], 4*w+3), pix(a[15], 4*w+2), pix(a[15], 4*w+1), pix(a[15], 4*w)};
  endfunction

  // Expected buffer per frame: frames 0..3 use 0,1,0,1.
  logic [3:0] exp_buf = 4'b1010;

  // Avalon-MM slave model: random stalls, fixed response latency, in-order data.
  typedef struct {
    logic [31:0] d;
    int          due;
  } rsp_t;

  rsp_t q[$];
  int   cyc = 0;
  int   lat = 1;
  bit   wait_rand = 1'b0;
  bit   addr_chk_en = 1'b1;
  int   acc_count = 0;
  int   max_inflight = 0;
  int   ovf = 0;

  always @(negedge clk) begin
    int f;
    int inflight;
    rsp_t r;
    cyc++;
    avm_fbuff_readdatavalid = 1'b0;
    avm_fbuff_readdata      = 32'h0;
    if (!reset) begin
      q.delete();
      avm_fbuff_waitrequest = 1'b0;
    end else begin
      if (q.size() > 0 && q[0].due <= cyc) begin
        avm_fbuff_readdatavalid = 1'b1;
        avm_fbuff_readdata      = q[0].d;
        void'(q.pop_front());
      end
      avm_fbuff_waitrequest = wait_rand && ($urandom_range(3) == 0);
      if (avm_fbuff_read && !avm_fbuff_waitrequest) begin
        if (addr_chk_en) begin
          f = acc_count / WORDS;
          if (f > 3) check("extra_read", acc_count, 4 * WORDS);
          else check("addr", avm_fbuff_address, {exp_buf[f], 15'(acc_count % WORDS)});
        end
        r.d   = mem_word(avm_fbuff_address);
        r.due = cyc + lat;
        q.push_back(r);
        acc_count++;
      end
      inflight = q.size() + (avm_fbuff_readdatavalid ? 1 : 0);
      if (inflight > max_inflight) max_inflight = inflight;
      if (avm_fbuff_readdatavalid && dut.fifo_full && !dut.fifo_pop) ovf++;
    end
  end

  // Pixel stream monitor.
  bit         mon_en = 1'b0;
  int         pix_total = 0;
  int         frame_cnt = 0;
  logic       eop_fire_prev = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h0;

  always @(negedge clk) begin
    int f;
    int idx;
    if (!mon_en) begin
      eop_fire_prev = 1'b0;
      prev_stall    = 1'b0;
    end else begin
      check("frame_done", frame_done, eop_fire_prev);
      if (frame_done) frame_cnt++;
      if (prev_stall) begin
        check("hold_valid", aso_pix_valid, 1);
        check("hold_data", aso_pix_data, prev_data);
      end
      eop_fire_prev = 1'b0;
      if (aso_pix_valid && aso_pix_ready) begin
        f   = pix_total / PIX;
        idx = pix_total % PIX;
        check("pix_data", aso_pix_data, pix(exp_buf[f % 4], idx));
        check("pix_sop", aso_pix_sop, (idx == 0));
        check("pix_eop", aso_pix_eop, (idx == PIX - 1));
        eop_fire_prev = (idx == PIX - 1);
        pix_total++;
      end else if (!aso_pix_valid) begin
        check("idle_sop_eop", {aso_pix_sop, aso_pix_eop}, 2'b00);
      end
      prev_stall = aso_pix_valid && !aso_pix_ready;
      prev_data  = aso_pix_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ctrl_wr(input logic [1:0] d);
    avs_ctrl_write     = 1'b1;
    avs_ctrl_writedata = d;
    tick();
    avs_ctrl_write     = 1'b0;
    avs_ctrl_writedata = 2'b00;
  endtask

  task automatic wait_pix(input int n);
    for (int i = 0; i < 4000 && pix_total < n; i++) tick();
    check("wait_pix", (pix_total >= n), 1);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 4000 && frame_cnt < n; i++) tick();
    check("wait_frame", frame_cnt, n);
    $display("frame %0d done: buf=%0d pixels=%0d reads=%0d", n - 1, exp_buf[(n - 1) % 4], pix_total, acc_count);
  endtask

  initial begin
    int t;
    int a;
    int rd_seen;
    reset                   = 1'b0;
    avm_fbuff_waitrequest   = 1'b0;
    avm_fbuff_readdata      = 32'h0;
    avm_fbuff_readdatavalid = 1'b0;
    avs_ctrl_write          = 1'b0;
    avs_ctrl_writedata      = 2'b00;
    aso_pix_ready           = 1'b1;
    repeat (3) tick();

    check("rst_read", avm_fbuff_read, 0);
    check("rst_addr", avm_fbuff_address, 16'h0000);
    check("rst_valid", aso_pix_valid, 0);
    check("rst_data", aso_pix_data, 8'h00);
    check("rst_sop_eop", {aso_pix_sop, aso_pix_eop}, 2'b00);
    check("rst_frame_done", frame_done, 0);
    check("rst_ctrl", avs_ctrl_readdata, 4'b0000);
    $display("reset released");
    reset = 1'b1;
    tick();
    mon_en = 1'b1;

    // Frame 0: buffer 0, zero-wait slave.
    ctrl_wr(2'b01);
    t = 0;
    while (!avs_ctrl_readdata[3] && t < 20) begin tick(); t++; end
    check("busy_start", avs_ctrl_readdata[3], 1);
    t = 0;
    while (!aso_pix_valid && t < 50) begin tick(); t++; end
    check("first_pix_lat_ge3", (t >= 3), 1);
    wait_pix(10);
    ctrl_wr(2'b11);
    check("ctrl_midframe", avs_ctrl_readdata, 4'b1011);
    wait_frames(1);

    // Frame 1 starts by itself on buffer 1; slower slave; enable cleared mid-frame.
    lat = 5;
    wait_pix(PIX + 10);
    ctrl_wr(2'b10);
    wait_frames(2);
    repeat (5) tick();
    check("ctrl_after_f1", avs_ctrl_readdata, 4'b0110);
    check("reads_after_f1", acc_count, 2 * WORDS);
    check("read_idle_f1", avm_fbuff_read, 0);

    // Frame 2: buffer 0, random waitrequest, sink stalls mid-line.
    wait_rand = 1'b1;
    ctrl_wr(2'b01);
    wait_pix(2 * PIX + 20);
    aso_pix_ready = 1'b0;
    repeat (100) tick();
    a = acc_count;
    repeat (100) tick();
    check("stall_no_reads", acc_count, a);
    check("stall_valid", aso_pix_valid, 1);
    $display("sink stall released after 200 cycles, reads=%0d", acc_count);
    aso_pix_ready = 1'b1;
    ctrl_wr(2'b00);
    wait_frames(3);
    repeat (5) tick();
    check("ctrl_after_f2", avs_ctrl_readdata, 4'b0000);
    check("reads_after_f2", acc_count, 3 * WORDS);
    check("pixels_after_f2", pix_total, 3 * PIX);

    // Frame 3: buffer 1, reset pulse during FETCH.
    wait_rand = 1'b0;
    lat = 1;
    ctrl_wr(2'b11);
    for (int i = 0; i < 200 && acc_count < 3 * WORDS + 5; i++) tick();
    check("f3_reads_started", (acc_count >= 3 * WORDS + 5), 1);
    mon_en      = 1'b0;
    addr_chk_en = 1'b0;
    reset       = 1'b0;
    tick();
    check("mid_rst_read", avm_fbuff_read, 0);
    check("mid_rst_addr", avm_fbuff_address, 16'h0000);
    check("mid_rst_valid", aso_pix_valid, 0);
    check("mid_rst_data", aso_pix_data, 8'h00);
    check("mid_rst_ctrl", avs_ctrl_readdata, 4'b0000);
    check("mid_rst_frame_done", frame_done, 0);
    reset = 1'b1;
    $display("mid-frame reset applied at read %0d", acc_count);
    a = acc_count;
    rd_seen = 0;
    repeat (20) begin
      tick();
      if (avm_fbuff_read) rd_seen++;
    end
    check("no_read_after_rst", rd_seen, 0);
    check("no_accept_after_rst", acc_count, a);
    check("valid_after_rst", aso_pix_valid, 0);

    check("max_inflight", max_inflight, MAXP);
    check("fifo_overflow", ovf, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
Read-side counterpart of the framebuffer fill path. Fetches a selected 480x272, 8-bit-per-pixel framebuffer over an Avalon-MM pipelined read master and emits pixels in raster order as an Avalon-ST stream to the display/encoder. Framebuffer format matches the writers: 32-bit words, 120 words per row, pixel x=4k+i in byte lane i. Buffer select is address bit 15.

Parameters:
FIFO_DEPTH, 8, word FIFO entries (power of 2, 4..64); also the cap on outstanding reads.
MAX_PENDING, 4, max read requests in flight (must be <= FIFO_DEPTH).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0)
avm_fbuff_read  out  1  read request
avm_fbuff_address  out  16  word address: {buffernum, word_index[14:0]}
avm_fbuff_waitrequest  in  1  slave stall; hold read/address while high
avm_fbuff_readdata  in  32  returned word
avm_fbuff_readdatavalid  in  1  returned word valid (in request order)
avs_ctrl_write  in  1  control write strobe
avs_ctrl_writedata  in  2  bit0 enable, bit1 requested buffer
avs_ctrl_readdata  out  4  {busy, active_buf, pending_buf, enable}, combinational
aso_pix_data  out  8  pixel colour
aso_pix_valid  out  1  pixel valid
aso_pix_ready  in  1  sink ready
aso_pix_sop  out  1  high with pixel (0,0)
aso_pix_eop  out  1  high with pixel (479,271)
frame_done  out  1  1-cycle pulse after eop pixel accepted

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0; enable=0, pending_buf=0, active_buf=0; FIFO empty; counters 0; state IDLE.
- Control write: updates enable and pending_buf in the next cycle; never stalls.
- States: IDLE -> FETCH when enable==1, latching active_buf<=pending_buf and zeroing word_index, x, y. FETCH -> DRAIN after word 32639 is accepted by the slave. DRAIN -> IDLE on the cycle frame_done pulses; IDLE re-enters FETCH next cycle if enable still 1 (one idle cycle between frames).
- Enable/buffer changes mid-frame have no effect until the next frame start; clearing enable lets the current frame finish.
- Issue rule: read asserted in FETCH when outstanding < MAX_PENDING and outstanding + fifo_count < FIFO_DEPTH. Request accepted on read && !waitrequest; word_index then increments. Address/read held stable while waitrequest is high.
- Responses: readdatavalid pushes readdata into the FIFO and decrements outstanding; simultaneous accept and response leave outstanding unchanged. Response into a full FIFO is impossible by credit rule; bench asserts it never occurs.
- Unpacker: holds one word and byte index 0..3; valid when a word is held. Pixel = byte[index]. On valid&&ready: index++, x++; at index 3 pop next word (same-cycle pop allowed, no bubble when FIFO non-empty). x wraps 479->0 with y++; y wraps 271->0.
- sop/eop asserted only with their pixel; data/valid stable while ready low.
- busy = state != IDLE.
- Latency: first pixel valid no earlier than 3 cycles after FETCH entry with zero-wait slave.
- Reset mid-frame: all state discarded; in-flight responses are dropped (interconnect reset concurrently).

Decomposition:
- Package fb_pkg: FB_WIDTH=480, FB_HEIGHT=272, FB_WORDS_PER_LINE=120, FB_WORDS=32640, FB_BUF_BIT=15, state enum scan_state_t {IDLE, FETCH, DRAIN}.
- Sub-module fb_word_fifo (sync FIFO, push/pop/count/full/empty, same-cycle push+pop when full or empty-with-push handled).

Test Plan:
- Zero-wait slave, buffer 0, ready=1: 130560 pixels, sop at first, eop at last, frame_done 1 cycle later; addresses 0x0000..0x7F7F in order.
- Memory word 0x44332211 at addr 0x8000, buffer 1: first four pixels 0x11,0x22,0x33,0x44; all addresses have bit15=1.
- Random waitrequest plus 5-cycle read latency: outstanding never exceeds 4, FIFO never overflows, pixel sequence unchanged.
- ready held low 200 cycles mid-line: reads stop once credits exhausted, pixel data/valid held, resume with no loss or duplication.
- Write buffer=1 mid-frame: current frame stays on buffer 0, next frame addresses start at 0x8000; clear enable mid-frame -> frame completes, IDLE, busy=0.
- Drive reset=0 for one cycle mid-FETCH: all outputs 0 next cycle, enable=0, no further reads issued.
